// File: rtl/d_drain_arb.sv
// d_drain_arb: round-robin drain of two destination FIFOs into one valid/ready stream
// with a 2-entry skid buffer covering the FIFO read latency and saturating per-source counters.
module d_drain_arb #(
  parameter int DATA_SIZE = 6,
  parameter int CNT_W     = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 init,
  input  logic                 enable,
  input  logic                 fifo_empty_d0,
  input  logic                 fifo_empty_d1,
  input  logic [DATA_SIZE-1:0] data_out_0_cond,
  input  logic [DATA_SIZE-1:0] data_out_1_cond,
  output logic                 pop_d0,
  output logic                 pop_d1,
  output logic                 out_valid,
  output logic [DATA_SIZE-1:0] out_data,
  output logic                 out_dest,
  input  logic                 out_ready,
  output logic [CNT_W-1:0]     cnt_d0,
  output logic [CNT_W-1:0]     cnt_d1,
  output logic                 idle
);
  typedef enum logic [1:0] {IDLE, ACTIVE, DRAIN} state_t;
  state_t state, state_nx;
  logic [1:0] occ;
  logic inflight, fl_dest, last_grant, head, wr, deq, pop, any, credit;
  logic [1:0][DATA_SIZE-1:0] bdata;
  logic [1:0] bdest;
  assign any = !fifo_empty_d0 || !fifo_empty_d1;
  assign out_valid = occ != 2'd0;
  assign deq = out_valid && out_ready;
  // occ + inflight - deq < 2, rearranged to avoid underflow
  assign credit = ({1'b0, occ} + {2'b0, inflight}) < (3'd2 + {2'b0, deq});
  assign pop = pop_d0 || pop_d1;
  // tail slot; when full it reuses the head slot being dequeued this cycle
  assign wr = head ^ occ[0];
  always_ff @(posedge clk or posedge reset)
    if (reset) state <= IDLE;
    else state <= state_nx;
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    state_nx = (enable && any) ? ACTIVE : IDLE;
      ACTIVE:  state_nx = (!enable || !any) ? DRAIN : ACTIVE;
      DRAIN:   state_nx = (enable && any) ? ACTIVE : (!inflight && occ == 2'd0) ? IDLE : DRAIN;
      default: state_nx = IDLE;
    endcase
  end
  always_comb begin
    pop_d0   = state == ACTIVE && enable && credit && !fifo_empty_d0 && (fifo_empty_d1 || last_grant);
    pop_d1   = state == ACTIVE && enable && credit && !fifo_empty_d1 && (fifo_empty_d0 || !last_grant);
    idle     = state == IDLE && !inflight && occ == 2'd0;
    out_data = out_valid ? bdata[head] : '0;
    out_dest = out_valid && bdest[head];
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      occ        <= 2'd0;
      inflight   <= 1'b0;
      fl_dest    <= 1'b0;
      head       <= 1'b0;
      bdata      <= '0;
      bdest      <= '0;
      last_grant <= 1'b1;
      cnt_d0     <= '0;
      cnt_d1     <= '0;
    end else begin
      inflight <= pop;
      if (pop) fl_dest <= pop_d1;
      if (inflight) begin
        bdata[wr] <= fl_dest ? data_out_1_cond : data_out_0_cond;
        bdest[wr] <= fl_dest;
      end
      head       <= head ^ deq;
      occ        <= occ + {1'b0, inflight} - {1'b0, deq};
      last_grant <= init ? 1'b1 : pop ? pop_d1 : last_grant;
      cnt_d0     <= init ? '0 : (deq && !out_dest && cnt_d0 != '1) ? cnt_d0 + 1'b1 : cnt_d0;
      cnt_d1     <= init ? '0 : (deq && out_dest && cnt_d1 != '1) ? cnt_d1 + 1'b1 : cnt_d1;
    end
endmodule

// File: tb/tb_d_drain_arb.sv
// tb_d_drain_arb: queue-based FIFO sources, rule checker on pops, scoreboard monitor on the output.
module tb_d_drain_arb;
  localparam int DW  = 6;
  localparam int CW  = 2;
  localparam int SAT = (1 << CW) - 1;
  logic clk = 0, reset = 1, init = 0, enable = 0, out_ready = 0;
  logic e0 = 1, e1 = 1;
  logic [DW-1:0] d0 = '0, d1 = '0;
  logic pop_d0, pop_d1, out_valid, out_dest, idle;
  logic [DW-1:0] out_data;
  logic [CW-1:0] cnt_d0, cnt_d1;
  d_drain_arb #(.DATA_SIZE(DW), .CNT_W(CW)) dut (
    .clk(clk), .reset(reset), .init(init), .enable(enable),
    .fifo_empty_d0(e0), .fifo_empty_d1(e1),
    .data_out_0_cond(d0), .data_out_1_cond(d1),
    .pop_d0(pop_d0), .pop_d1(pop_d1), .out_valid(out_valid), .out_data(out_data),
    .out_dest(out_dest), .out_ready(out_ready), .cnt_d0(cnt_d0), .cnt_d1(cnt_d1), .idle(idle)
  );
  always #5 clk = ~clk;
  int vectors = 0, miscompares = 0, cyc = 0;
  int npops, first_pop, last_pop, first_valid, mc0 = 0, mc1 = 0;
  logic [DW-1:0] q0[$], q1[$];
  logic [DW:0] exp_q[$];
  logic dlog[$];
  logic mlast = 1'b1;
  bit refill = 0, rinit = 0, rready = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] want);
    vectors++;
    if (act !== want) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, want, cyc);
    end
  endtask
  task automatic marks();
    npops = 0; first_pop = -1; last_pop = -1; first_valid = -1;
    dlog.delete();
  endtask
  // one clock: check pop legality mid-cycle, then model the FIFOs after the edge
  task automatic step();
    logic p0, p1, dq;
    @(negedge clk); #1;
    cyc++;
    p0 = pop_d0; p1 = pop_d1; dq = out_valid && out_ready;
    if (out_valid && first_valid < 0) first_valid = cyc;
    if (p0 || p1) begin
      chk("one_pop", p0 && p1, 0);
      chk("pop_nonempty", (p0 && e0) || (p1 && e1), 0);
      chk("credit", (exp_q.size() - int'(dq)) < 2, 1);
      if (!e0 && !e1) chk("round_robin", p1, !mlast);
      mlast = p1;
      npops++;
      if (first_pop < 0) first_pop = cyc;
      last_pop = cyc;
      if (p1 && q1.size() > 0) exp_q.push_back({1'b1, q1[0]});
      else if (p0 && q0.size() > 0) exp_q.push_back({1'b0, q0[0]});
    end
    if (rinit) init = !(p0 || p1) && $urandom_range(0, 40) == 0;
    if (init) mlast = 1'b1;
    @(posedge clk); #1;
    if (p0 && q0.size() > 0) d0 = q0.pop_front();
    if (p1 && q1.size() > 0) d1 = q1.pop_front();
    if (refill) begin
      if (q0.size() < 8 && $urandom_range(0, 2) == 0) q0.push_back(DW'($urandom));
      if (q1.size() < 8 && $urandom_range(0, 2) == 0) q1.push_back(DW'($urandom));
    end
    if (rready) out_ready = $urandom_range(0, 2) != 0;
    e0 = q0.size() == 0;
    e1 = q1.size() == 0;
  endtask
  task automatic do_reset();
    reset = 1; #1;
    chk("rst_valid", out_valid, 0);
    chk("rst_pops", {pop_d0, pop_d1}, 0);
    chk("rst_idle", idle, 1);
    chk("rst_cnt", {cnt_d0, cnt_d1}, 0);
    chk("rst_out", {out_dest, out_data}, 0);
    exp_q.delete(); q0.delete(); q1.delete();
    e0 = 1; e1 = 1; d0 = '0; d1 = '0; mlast = 1'b1; init = 0;
    step();
    reset = 0;
  endtask
  task automatic drain(input int budget);
    int n = 0;
    while (n < budget && !(exp_q.size() == 0 && idle && q0.size() == 0 && q1.size() == 0)) begin
      step(); n++;
    end
    chk("drain_timeout", n < budget, 1);
  endtask
  initial begin
    logic [DW:0] w;
    forever begin
      @(negedge clk); #2;
      if (reset) begin
        mc0 = 0; mc1 = 0;
      end else begin
        chk("cnt_d0", cnt_d0, mc0);
        chk("cnt_d1", cnt_d1, mc1);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_word", 1, 0);
          else begin
            w = exp_q.pop_front();
            chk("out_dest", out_dest, w[DW]);
            chk("out_data", out_data, w[DW-1:0]);
            dlog.push_back(out_dest);
            if (out_dest) mc1 = mc1 < SAT ? mc1 + 1 : SAT;
            else mc0 = mc0 < SAT ? mc0 + 1 : SAT;
          end
        end
        if (init) begin mc0 = 0; mc1 = 0; end
      end
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end
  initial begin
    marks();
    do_reset();
    // single source
    marks();
    q0 = '{6'h05, 6'h0A, 6'h11}; e0 = 0; enable = 1; out_ready = 1;
    drain(40);
    chk("ss_pops", npops, 3);
    chk("ss_consecutive", last_pop - first_pop, 2);
    chk("ss_latency", first_valid - first_pop, 2);
    chk("ss_words", dlog.size(), 3);
    chk("ss_cnt_d0", cnt_d0, 3 < SAT ? 3 : SAT);
    // round robin, first tie to D0 after reset
    do_reset();
    marks();
    for (int i = 0; i < 4; i++) begin q0.push_back(6'h01); q1.push_back(6'h3F); end
    e0 = 0; e1 = 0; enable = 1; out_ready = 1;
    drain(60);
    chk("rr_pops", npops, 8);
    chk("rr_throughput", last_pop - first_pop, 7);
    chk("rr_words", dlog.size(), 8);
    for (int i = 0; i < 8 && i < dlog.size(); i++) chk("rr_order", dlog[i], i % 2);
    chk("rr_cnt_d0", cnt_d0, 4 < SAT ? 4 : SAT);
    chk("rr_cnt_d1", cnt_d1, 4 < SAT ? 4 : SAT);
    // backpressure
    marks();
    for (int i = 0; i < 8; i++) begin q0.push_back(DW'($urandom)); q1.push_back(DW'($urandom)); end
    e0 = 0; e1 = 0; out_ready = 0; enable = 1;
    repeat (10) step();
    chk("bp_pops", npops, 2);
    chk("bp_full_valid", out_valid, 1);
    out_ready = 1;
    drain(100);
    chk("bp_words", dlog.size(), 16);
    // enable drop with one word in flight
    marks();
    for (int i = 0; i < 3; i++) q0.push_back(DW'($urandom));
    e0 = 0; enable = 1; out_ready = 1;
    for (int n = 0; n < 10 && npops == 0; n++) step();
    chk("ed_first_pop", npops, 1);
    enable = 0;
    repeat (8) step();
    chk("ed_no_pops", npops, 1);
    chk("ed_idle", idle, 1);
    chk("ed_delivered", dlog.size(), 1);
    chk("ed_pending", q0.size(), 2);
    enable = 1;
    drain(40);
    // saturation and init
    init = 1; step(); init = 0; step();
    chk("init_clear_d0", cnt_d0, 0);
    for (int i = 0; i < 5; i++) q1.push_back(DW'($urandom));
    e1 = 0;
    drain(40);
    chk("sat_cnt_d1", cnt_d1, 5 < SAT ? 5 : SAT);
    init = 1; step(); init = 0;
    chk("init_clear_d1", cnt_d1, 0);
    // randomized traffic with random init, enable, backpressure and one reset
    refill = 1; rinit = 1; rready = 1;
    for (int i = 0; i < 3000; i++) begin
      enable = $urandom_range(0, 7) != 0;
      if (i == 1500) do_reset();
      else step();
    end
    refill = 0; rinit = 0; rready = 0; init = 0; enable = 1; out_ready = 1;
    drain(200);
    // reset mid-stream with a full buffer
    for (int i = 0; i < 4; i++) begin q0.push_back(DW'($urandom)); q1.push_back(DW'($urandom)); end
    e0 = 0; e1 = 0; out_ready = 0; enable = 1;
    repeat (6) step();
    chk("pre_reset_valid", out_valid, 1);
    do_reset();
    step();
    chk("post_reset_idle", idle, 1);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/d_drain_arb.md
# d_drain_arb

Output-side drain arbiter that empties the two destination FIFOs (D0, D1) into a single valid/ready output stream. It sits directly downstream of the D0/D1 FIFOs of the flow-control datapath. It watches their empty flags, drives their pop strobes with round-robin fairness, absorbs the FIFOs' one-cycle read latency in a 2-entry output buffer, and keeps per-destination delivered-word counters.

## Interface
- DATA_SIZE, 6, word width of D FIFO data and out_data
- CNT_W, 8, width of each delivered-word counter
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high reset
- init  in  1  synchronous clear of counters and arbitration pointer
- enable  in  1  allows new pops when high
- fifo_empty_d0  in  1  D0 empty flag, registered, reflects post-pop state on the cycle after a pop
- fifo_empty_d1  in  1  D1 empty flag, same rules as D0
- data_out_0_cond  in  DATA_SIZE  D0 read data, valid the cycle after pop_d0
- data_out_1_cond  in  DATA_SIZE  D1 read data, valid the cycle after pop_d1
- pop_d0  out  1  combinational pop strobe to D0
- pop_d1  out  1  combinational pop strobe to D1
- out_valid  out  1  head of output buffer valid
- out_data  out  DATA_SIZE  head word
- out_dest  out  1  source of head word, 0 = D0, 1 = D1
- out_ready  in  1  consumer accepts head when out_valid && out_ready
- cnt_d0  out  CNT_W  words from D0 delivered since reset/init
- cnt_d1  out  CNT_W  words from D1 delivered since reset/init
- idle  out  1  state IDLE, no in-flight read, buffer empty

## Operation
- State machine has three states, encoded in a registered state:
  - IDLE: no pops.
  - ACTIVE: pops allowed.
  - DRAIN: no new pops, remaining words are flushed.
- Transitions:
  - IDLE -> ACTIVE when enable and (!fifo_empty_d0 or !fifo_empty_d1).
  - ACTIVE -> DRAIN when !enable, or when both FIFOs are empty with no pop this cycle.
  - DRAIN -> IDLE when inflight == 0 and occ == 0.
  - DRAIN -> ACTIVE when enable and a FIFO is non-empty.
- Credit rule: a pop is allowed in ACTIVE only if occ + inflight - deq < 2.
  - occ is buffer occupancy, 0..2.
  - inflight is 1 if a pop was issued in the previous cycle.
  - deq = out_valid && out_ready.
- Arbitration:
  - At most one pop per cycle, and never to a FIFO whose empty flag is high.
  - If exactly one FIFO is non-empty, that one is popped.
  - If both are non-empty, pop the one not granted last; last_grant flips only on an actual pop.
- Capture: the cycle after pop_dX, the registered {dest, data_out_X_cond} is written into the buffer tail.
  - Enqueue and dequeue in the same cycle are legal, and occ is unchanged.
  - The credit rule guarantees the buffer never overflows; an enqueue into a full buffer must not occur.
- Buffer is a 2-entry FIFO; out_valid = (occ != 0) and out_data/out_dest come from the head entry.
- Counters: on each dequeue, increment cnt_d0 or cnt_d1 by out_dest.
  - Counters saturate at 2^CNT_W-1 and do not wrap.
- init, sampled on a clock edge:
  - clears cnt_d0, cnt_d1 and last_grant (so the next tie goes to D0).
  - does not flush the buffer or the in-flight word.
  - takes precedence over a same-cycle counter increment.
- Reset values: state=IDLE, occ=0, inflight=0, last_grant=1, cnt_d0=cnt_d1=0.
  - Resulting outputs in reset: out_valid=0, out_data=0, out_dest=0, pop_d0=pop_d1=0, idle=1.
- Reset asserted mid-operation: buffered and in-flight words are discarded, and pops drop in the same cycle because they are gated by state.

## Timing
- Pop to out_valid latency: pop in cycle N, data sampled at the end of N+1, out_valid high in N+2.
- Throughput: 1 word/cycle sustained with out_ready held high and a source non-empty.
- out_ready low: at most 2 further pops complete (buffer fills); pops then stop until a dequeue.
- pop_dX is combinational from state, empties, occ, inflight, out_ready and enable. There is no combinational path from data inputs to outputs.
- idle deasserts one cycle after a non-empty flag is seen with enable high.

## Test plan
- Reset: assert reset mid-stream with occ=2 -> out_valid=0, pops=0 and idle=1 immediately; cnt_d0=cnt_d1=0.
- Single source: D0 holds 0x05, 0x0A, 0x11 and out_ready=1 -> pop_d0 on 3 consecutive cycles; words delivered in order with out_dest=0 starting 2 cycles after the first pop; cnt_d0=3.
- Round-robin: both FIFOs hold 4 words, all D0 words 0x01 and all D1 words 0x3F -> output alternates D0, D1, D0, ... (first grant D0 after reset); cnt_d0=cnt_d1=4.
- Backpressure: both FIFOs full and out_ready=0 for 10 cycles -> exactly 2 pops occur, occ=2, no further pops. Then release -> no word lost or duplicated.
- Enable drop: deassert enable with 1 word in flight -> state DRAIN, no new pops, in-flight word delivered, then IDLE and idle=1.
- Counter saturation with CNT_W=2: deliver 5 D1 words -> cnt_d1 stops at 3. Then pulse init -> cnt_d1=0 on the next cycle.
